mem_arb_rr: RTL

- N-master to 1-slave Avalon-MM arbiter for the SRAM path; the successor to the fixed two-slave, read-priority arbiter in front of sram_arb.
- Round-robin fair arbitration, with the grant locked across downstream waitrequest.
- Supports pipelined reads with multiple outstanding transactions: an internal tag FIFO routes each readdatavalid back to the master that issued the read.
- Sits between stim/check (and future DMA) masters and sram_arb.

---
 rtl/mem_arb_rr_if.sv | 24 ++
 rtl/mem_arb_rr.sv | 67 ++++++
 2 files changed

// File: rtl/mem_arb_rr_if.sv
// mem_arb_rr_if: Avalon-MM bundle with N request lanes sharing one readdata bus.
interface mem_arb_rr_if #(
  parameter int N  = 1,
  parameter int AW = 20,
  parameter int DW = 16,
  parameter int BW = DW / 8
);
  logic [N*AW-1:0] address;
  logic [N*BW-1:0] byteenable;
  logic [N-1:0]    read;
  logic [N-1:0]    write;
  logic [N*DW-1:0] writedata;
  logic [N-1:0]    waitrequest;
  logic [DW-1:0]   readdata;
  logic [N-1:0]    readdatavalid;
  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: round-robin N-master to 1-slave Avalon-MM arbiter with read-tag return routing.
module mem_arb_rr #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 16,
  parameter int BE_WIDTH    = DATA_WIDTH / 8,
  parameter int MAX_PENDING = 4,
  parameter int ID_WIDTH    = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  mem_arb_rr_if.slave                    m,
  mem_arb_rr_if.master                   s,
  output logic [$clog2(MAX_PENDING):0]   pending,
  output logic                           err_unexpected
);
  localparam int PW = $clog2(MAX_PENDING);
  logic [ID_WIDTH-1:0]    last_grant, locked_id, scan, g;
  logic [ID_WIDTH-1:0]    tags [MAX_PENDING];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [NUM_MASTERS-1:0] req;
  logic                   lock, full, empty, valid, accept, push, pop;
  always_comb begin
    full  = pending == (PW+1)'(MAX_PENDING);
    empty = pending == '0;
    // a master asserting both read and write is treated as a read
    for (int i = 0; i < NUM_MASTERS; i++) req[i] = m.read[i] ? ~full : m.write[i];
    scan = last_grant;
    for (int k = NUM_MASTERS; k >= 1; k--)
      if (req[(int'(last_grant) + k) % NUM_MASTERS]) scan = ID_WIDTH'((int'(last_grant) + k) % NUM_MASTERS);
    g      = lock ? locked_id : scan;
    valid  = req[g];
    s.read       = valid & m.read[g];
    s.write      = valid & m.write[g] & ~m.read[g];
    s.address    = m.address[int'(g)*ADDR_WIDTH +: ADDR_WIDTH];
    s.byteenable = m.byteenable[int'(g)*BE_WIDTH +: BE_WIDTH];
    s.writedata  = m.writedata[int'(g)*DATA_WIDTH +: DATA_WIDTH];
    accept = valid & ~s.waitrequest[0];
    push   = accept & m.read[g];
    pop    = s.readdatavalid[0] & ~empty;
    m.waitrequest = '1;
    if (valid) m.waitrequest[g] = s.waitrequest[0];
    m.readdata      = s.readdata;
    m.readdatavalid = '0;
    if (pop) m.readdatavalid[tags[rd_ptr]] = 1'b1;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      last_grant     <= ID_WIDTH'(NUM_MASTERS - 1);
      lock           <= 1'b0;
      locked_id      <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      pending        <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (accept) last_grant <= g;
      lock      <= valid & s.waitrequest[0];
      locked_id <= g;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      pending <= pending + (PW+1)'(push) - (PW+1)'(pop);
      if (s.readdatavalid[0] & empty) err_unexpected <= 1'b1;
    end
  always_ff @(posedge clock)
    if (push) tags[wr_ptr] <= g;
endmodule
